rv32_dmem_responder: RTL and testbench
======================================

Name: rv32_dmem_responder

Overview:
- Data-memory responder that sits on the load/store port of the RISC_V core and is the target of every LB/LH/LW/LBU/LHU/SB/SH/SW.
- The core is the initiator; this block accepts one request at a time, performs byte-lane writes or aligned reads, and returns sign- or zero-extended load data.
- Returns an error flag for illegal accesses.
- Instantiated beside the instruction fetch unit inside the top-level core wrapper.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage; word index = req_addr[31:2].
- RD_LATENCY, 1, cycles from request accept to load response; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU); ignored for stores and word loads
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  core takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal-size access
- tohost_valid  out  1  one-cycle pulse on a tohost write (optional feature)
- tohost_data  out  32  last tohost value (optional feature)

Behaviour:
- Reset:
  - State goes to IDLE.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, tohost_valid=0, tohost_data=0.
  - Memory contents are not cleared.
- Accept: a request is accepted on a clock edge where req_valid=1 and req_ready=1. The block captures addr, size, we, unsigned and wdata at that edge.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On accept, go to WAIT if RD_LATENCY>1 and the access is a legal load; otherwise go to RESP.
  - WAIT: req_ready=0. A counter runs until RD_LATENCY-1 cycles have elapsed since accept, then the block goes to RESP.
  - RESP: rsp_valid=1 and rsp_rdata/rsp_err are held stable. When rsp_ready=1 the block goes to IDLE; req_ready becomes 1 on the following cycle. There is no same-cycle re-accept.
- Latency:
  - Legal load: rsp_valid is asserted exactly RD_LATENCY cycles after the accept edge.
  - Store or error: rsp_valid is asserted 1 cycle after the accept edge.
- Error conditions (checked in priority order):
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - word index >= DEPTH_WORDS
- On error: no memory write occurs, rsp_err=1, rsp_rdata=0.
- Stores:
  - Write enables are derived from size and addr[1:0]: byte uses lane addr[1:0]; half uses lanes {addr[1],0} and +1; word uses all lanes.
  - The write commits on the accept edge.
- Loads:
  - Read the word, select the lane by addr[1:0], and extend to 32 bits.
  - Sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned=1.
- Read-after-write: a load accepted the cycle after a store response completes returns the new data. No stale read is allowed.
- Reset mid-operation: WAIT or RESP is abandoned and any pending response is dropped. A store that was already accepted remains committed.

Optional Feature:
- Macro: DMEM_TOHOST_EN.
- Defined:
  - A word store to byte address 0xFFFF_FFF0 is not range-checked.
  - tohost_data is updated with req_wdata and tohost_valid pulses high for 1 cycle after the accept edge.
  - Normal store response with rsp_err=0; storage is unmodified.
  - A load from that address returns tohost_data.
- Not defined:
  - The address is treated as ordinary (out of range) and gets an error response.
  - tohost_valid and tohost_data are tied to 0.

Decomposition:
- Package rv32_dmem_pkg holds:
  - req_size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state enum
  - TOHOST_ADDR constant 32'hFFFF_FFF0
- One sub-module, rv32_lane_align (combinational):
  - store byte-enable and lane-shifted write-data generation
  - load lane extraction with sign/zero extension
- The FSM, latency counter and storage array remain in the top module.

Test Plan:
- SW 0x8765_4321 to 0x10, then LW 0x10 -> rsp_rdata=0x8765_4321, rsp_err=0, rsp_valid exactly RD_LATENCY cycles after accept.
- After the above, LB 0x13 -> 0xFFFF_FF87; LBU 0x13 -> 0x0000_0087; LH 0x12 -> 0xFFFF_8765; LHU 0x10 -> 0x0000_4321.
- SB 0xAA to 0x11, then LW 0x10 -> 0x8765_AA21; the other lanes are untouched.
- LH 0x11, SW 0x12, req_size=11, LW to DEPTH_WORDS*4 -> each returns rsp_err=1, rsp_rdata=0; a subsequent LW 0x10 shows memory unchanged.
- Hold rsp_ready=0 for 5 cycles with RD_LATENCY=3 -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; accept resumes the cycle after rsp_ready=1.
- Assert rst while in WAIT -> next cycle rsp_valid=0, req_ready=1. With DMEM_TOHOST_EN, SW 0x1 to 0xFFFF_FFF0 -> tohost_valid pulses once and tohost_data=0x1.

Source files
------------

// File: rtl/rv32_dmem_pkg.sv
// Shared encodings for the RV32 data-memory responder: access sizes, FSM states
// and the tohost mailbox address.
package rv32_dmem_pkg;

    localparam logic [1:0]  SZ_BYTE     = 2'b00;
    localparam logic [1:0]  SZ_HALF     = 2'b01;
    localparam logic [1:0]  SZ_WORD     = 2'b10;
    localparam logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/rv32_lane_align.sv
// Byte-lane steering for the data memory: store byte enables / replicated write
// data, and load lane extraction with sign or zero extension.
module rv32_lane_align
    import rv32_dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Lane selection; write data is replicated so every enabled lane sees its byte.
    always_comb begin
        o_be      = 4'b0000;
        o_wdata   = 32'h0000_0000;
        o_rdata   = 32'h0000_0000;
        w_shifted = i_rword >> {i_addr_lo, 3'b000};
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = 32'h0000_0000;
                o_rdata = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Single-outstanding data-memory responder for the RV32 load/store port.
// Optional tohost mailbox at TOHOST_ADDR is enabled by defining DMEM_TOHOST_EN.
module rv32_dmem_responder
    import rv32_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] r_mem [DEPTH_WORDS];
    dmem_state_t r_state;
    logic [2:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic          w_th_hit;
    logic [31:0]   w_th_word;
    logic          w_err;
    logic          w_load_ok;
    logic          w_do_write;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_ld_data;

    assign w_accept   = req_valid & r_req_ready & ~rst;
    assign w_idx      = req_addr[AW+1:2];
    // The tohost address bypasses the range check only; the mailbox never touches storage.
    assign w_err      = (req_size == 2'b11)
                      | ((req_size == SZ_HALF) & req_addr[0])
                      | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                      | (({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) & ~w_th_hit);
    assign w_load_ok  = ~req_we & ~w_err;
    assign w_do_write = w_accept & req_we & ~w_err & ~w_th_hit;
    assign w_rword    = w_th_hit ? w_th_word : r_mem[w_idx];

    rv32_lane_align u_align (
        .i_size     (req_size),
        .i_addr_lo  (req_addr[1:0]),
        .i_unsigned (req_unsigned),
        .i_wdata    (req_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_ld_data)
    );

    // Byte-lane store commit on the accept edge.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM; load data is captured at accept and held until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_cnt       <= 3'd1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= w_load_ok ? w_ld_data : 32'h0000_0000;
                        if (w_load_ok && (RD_LATENCY > 1)) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'(RD_LATENCY - 1)) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'h0000_0000;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'h0000_0000;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

`ifdef DMEM_TOHOST_EN
    logic        r_tohost_valid;
    logic [31:0] r_tohost_data;

    assign w_th_hit  = (req_addr == TOHOST_ADDR) & (req_size == SZ_WORD);
    assign w_th_word = r_tohost_data;

    // Mailbox register with a one-cycle strobe per accepted tohost store.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tohost_valid <= 1'b0;
            r_tohost_data  <= 32'h0000_0000;
        end else begin
            r_tohost_valid <= w_accept & req_we & w_th_hit;
            if (w_accept && req_we && w_th_hit) begin
                r_tohost_data <= req_wdata;
            end
        end
    end

    assign tohost_valid = r_tohost_valid;
    assign tohost_data  = r_tohost_data;
`else
    assign w_th_hit     = 1'b0;
    assign w_th_word    = 32'h0000_0000;
    assign tohost_valid = 1'b0;
    assign tohost_data  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Self-checking bench for rv32_dmem_responder: byte-array reference model with a
// per-cycle compare process, directed literal cases, then randomized traffic.
module tb_rv32_dmem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        tohost_valid;
    logic [31:0] tohost_data;

    always #5 clk = ~clk;

    rv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .tohost_valid(tohost_valid), .tohost_data(tohost_data)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          seen_reset = 1'b0;
    bit          in_flight = 1'b0;
    int          acc_cyc = 0;
    int          exp_lat = 1;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_err = 1'b0;
    int          n_acc = 0;
    int          th_cyc = -10;
    int          th_pulses = 0;
    logic [31:0] model_tohost = 32'h0;
    logic [7:0]  mmem [DEPTH*4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed memory, rules applied directly from the access description.
    function automatic void model_eval(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                       input bit uns, input logic [31:0] wdata,
                                       output bit err, output logic [31:0] rdata,
                                       output bit th_wr, output int lat);
        int unsigned nb;
        bit          hit;
        logic [31:0] v;
        hit = 1'b0;
`ifdef DMEM_TOHOST_EN
        hit = (addr == 32'hFFFF_FFF0) && (size == 2'd2);
`endif
        nb    = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
        err   = (size == 2'd3) || ((addr % nb) != 0) || (!hit && ((addr / 4) >= DEPTH));
        rdata = 32'h0;
        th_wr = 1'b0;
        v     = 32'h0;
        lat   = (!err && !we) ? LAT : 1;
        if (!err) begin
            if (we) begin
                if (hit) begin
                    th_wr        = 1'b1;
                    model_tohost = wdata;
                end else begin
                    for (int i = 0; i < int'(nb); i++) mmem[addr + i] = wdata[8*i +: 8];
                end
            end else begin
                if (hit) v = model_tohost;
                else for (int i = 0; i < int'(nb); i++) v[8*i +: 8] = mmem[addr + i];
                if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                rdata = v;
            end
        end
    endfunction

    // Model advance at each rising edge, from the bench's own view of handshakes.
    always @(posedge clk) begin
        bit          e;
        bit          t;
        logic [31:0] r;
        int          l;
        cyc++;
        if (rst) begin
            in_flight    = 1'b0;
            seen_reset   = 1'b1;
            th_cyc       = -10;
            model_tohost = 32'h0;
        end else if (in_flight) begin
            if (((cyc - acc_cyc) >= exp_lat) && rsp_ready) in_flight = 1'b0;
        end else if (req_valid) begin
            model_eval(req_we, req_addr, req_size, req_unsigned, req_wdata, e, r, t, l);
            exp_err   = e;
            exp_rdata = r;
            exp_lat   = l;
            in_flight = 1'b1;
            acc_cyc   = cyc;
            n_acc++;
            if (t) th_cyc = cyc;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit ev;
        if (seen_reset) begin
            ev = in_flight && ((cyc - acc_cyc + 1) >= exp_lat);
            chk("req_ready", req_ready, !in_flight);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", rsp_err, exp_err);
            end
            chk("tohost_valid", tohost_valid, th_cyc == cyc);
            chk("tohost_data", tohost_data, model_tohost);
            if (tohost_valid === 1'b1) th_pulses++;
        end
    end

    task automatic txn(input bit we, input logic [31:0] addr, input logic [1:0] size, input bit uns,
                       input logic [31:0] wdata, input int stall, input logic [31:0] exp_rd,
                       input bit exp_e, input int exp_l, input string name);
        int n0;
        int t;
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = (stall == 0);
        n0 = n_acc;
        t  = 0;
        do begin @(negedge clk); t++; end while (n_acc == n0 && t < 50);
        req_valid = 1'b0;
        if (n_acc == n0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: accept timeout", name);
            rsp_ready = 1'b1;
            return;
        end
        t = 1;
        while (rsp_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        chk({name, " latency"}, t, exp_l);
        chk({name, " rdata"}, rsp_rdata, exp_rd);
        chk({name, " err"}, rsp_err, exp_e);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            rsp_ready = 1'b1;
        end
        t = 0;
        while (in_flight && t < 50) begin @(negedge clk); t++; end
    endtask

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [31:0] a;
        int          r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset req_ready", req_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset tohost_valid", tohost_valid, 0);
        chk("reset tohost_data", tohost_data, 0);

        for (int i = 0; i < 16; i++)
            txn(1'b1, 32'(i * 4), 2'd2, 1'b0, 32'hC0DE_0000 | 32'(i), 0, 32'h0, 1'b0, 1, "init");
        txn(1'b1, 32'((DEPTH - 1) * 4), 2'd2, 1'b0, 32'h5A5A_C3C3, 0, 32'h0, 1'b0, 1, "init_top");

        txn(1'b1, 32'h10, 2'd2, 1'b0, 32'h8765_4321, 0, 32'h0, 1'b0, 1, "sw_10");
        txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 32'h8765_4321, 1'b0, LAT, "lw_10");
        txn(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0, 32'hFFFF_FF87, 1'b0, LAT, "lb_13");
        txn(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0, 32'h0000_0087, 1'b0, LAT, "lbu_13");
        txn(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 0, 32'hFFFF_8765, 1'b0, LAT, "lh_12");
        txn(1'b0, 32'h10, 2'd1, 1'b1, 32'h0, 0, 32'h0000_4321, 1'b0, LAT, "lhu_10");
        txn(1'b1, 32'h11, 2'd0, 1'b0, 32'h1234_56AA, 0, 32'h0, 1'b0, 1, "sb_11");
        txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 32'h8765_AA21, 1'b0, LAT, "lw_after_sb");
        txn(1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 0, 32'hFFFF_FFAA, 1'b0, LAT, "lb_11");
        txn(1'b0, 32'h10, 2'd0, 1'b0, 32'h0, 0, 32'h0000_0021, 1'b0, LAT, "lb_10");
        txn(1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 0, 32'h0, 1'b1, 1, "lh_11_misalign");
        txn(1'b1, 32'h12, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 32'h0, 1'b1, 1, "sw_12_misalign");
        txn(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 0, 32'h0, 1'b1, 1, "size_11");
        txn(1'b0, 32'(DEPTH * 4), 2'd2, 1'b0, 32'h0, 0, 32'h0, 1'b1, 1, "lw_range");
        txn(1'b1, 32'(DEPTH * 4), 2'd2, 1'b0, 32'h1111_1111, 0, 32'h0, 1'b1, 1, "sw_range");
        txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 32'h8765_AA21, 1'b0, LAT, "lw_unchanged");
        txn(1'b0, 32'((DEPTH - 1) * 4), 2'd2, 1'b0, 32'h0, 0, 32'h5A5A_C3C3, 1'b0, LAT, "lw_top");
        txn(1'b1, 32'h16, 2'd1, 1'b0, 32'hFFFF_BEEF, 0, 32'h0, 1'b0, 1, "sh_16");
        txn(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, 0, 32'hBEEF_0005, 1'b0, LAT, "lw_14");
        txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, 32'h8765_AA21, 1'b0, LAT, "lw_stall");

        // Reset while a load waits, then reset while a store response is pending.
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait rsp_valid", rsp_valid, 0);
        chk("rst_wait req_ready", req_ready, 1);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, 32'hCAFE_F00D, 1'b0, LAT, "lw_after_rst_store");

`ifdef DMEM_TOHOST_EN
        th_pulses = 0;
        txn(1'b1, 32'hFFFF_FFF0, 2'd2, 1'b0, 32'h1, 0, 32'h0, 1'b0, 1, "tohost_sw");
        chk("tohost_data literal", tohost_data, 32'h1);
        chk("tohost pulse count", th_pulses, 1);
        txn(1'b0, 32'hFFFF_FFF0, 2'd2, 1'b0, 32'h0, 0, 32'h1, 1'b0, LAT, "tohost_lw");
`else
        txn(1'b1, 32'hFFFF_FFF0, 2'd2, 1'b0, 32'h1, 0, 32'h0, 1'b1, 1, "tohost_sw_err");
        chk("tohost_data tied", tohost_data, 32'h0);
`endif

        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            r = $urandom_range(0, 19);
            if (r < 16)      a = $urandom_range(0, 63);
            else if (r < 18) a = 32'((DEPTH - 1) * 4) + $urandom_range(0, 3);
            else if (r < 19) a = 32'(DEPTH * 4) + $urandom_range(0, 7);
            else             a = 32'hFFFF_FFF0;
            r = $urandom_range(0, 9);
            req_size     = (r < 3) ? 2'd0 : ((r < 6) ? 2'd1 : ((r < 9) ? 2'd2 : 2'd3));
            req_addr     = a;
            req_we       = $urandom_range(0, 1) == 1;
            req_unsigned = $urandom_range(0, 1) == 1;
            req_wdata    = $urandom;
            req_valid    = $urandom_range(0, 3) != 0;
            rsp_ready    = $urandom_range(0, 2) != 0;
            rst          = $urandom_range(0, 299) == 0;
        end
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
